// File: rtl/out_fifo_network.sv
// Egress merge: per-node FIFOs feeding one Avalon-ST source through a
// packet-atomic round-robin arbiter.
//
// state | meaning
// IDLE  | searching from ptr for a non-empty FIFO; drops heads without sop
// SEND  | forwarding words of FIFO[grant] until a word with eop is loaded
module out_fifo_network #(
  parameter int ncount     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic [ncount*138-1:0]  pnode_data,
  input  logic [ncount-1:0]      pnode_valid,
  output logic [ncount-1:0]      pnode_ready,
  output logic [127:0]           st_data,
  output logic [7:0]             st_channel,
  output logic                   st_sop,
  output logic                   st_eop,
  output logic                   st_valid,
  input  logic                   st_ready,
  output logic [15:0]            drop_count,
  output logic [31:0]            pkt_count
);

  localparam int NW = (ncount > 1) ? $clog2(ncount) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, state_nx;
  logic [NW-1:0]            grant, grant_nx;
  logic [NW-1:0]            ptr, ptr_nx;
  logic [ncount-1:0]        empty;
  logic [ncount-1:0]        pop;
  logic [ncount-1:0][137:0] head;
  logic                     load;
  logic                     drop;
  logic                     found;
  logic [NW-1:0]            sel;
  logic [NW-1:0]            cand;
  int                       idx;

  for (genvar g = 0; g < ncount; g++) begin : g_fifo
    logic [137:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          wr;

    // Readiness comes from the registered count only, so a pop never frees
    // a slot for a write in the same cycle.
    assign pnode_ready[g] = (cnt != FULL_CNT);
    assign wr             = pnode_valid[g] && pnode_ready[g];
    assign empty[g]       = (cnt == '0);
    assign head[g]        = mem[rd_ptr];

    always_ff @(posedge clock) begin
      if (wr) mem[wr_ptr] <= pnode_data[g*138 +: 138];
    end

    always_ff @(posedge clock) begin
      if (sclr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr)     wr_ptr <= wr_ptr + 1'b1;
        if (pop[g]) rd_ptr <= rd_ptr + 1'b1;
        if (wr && !pop[g])      cnt <= cnt + 1'b1;
        else if (!wr && pop[g]) cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx   = ptr;
    pop      = '0;
    load     = 1'b0;
    drop     = 1'b0;
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    idx      = 0;

    for (int k = 0; k < ncount; k++) begin
      idx = int'(ptr) + k;
      if (idx >= ncount) idx = idx - ncount;
      cand = NW'(idx);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          if (head[sel][129]) begin
            grant_nx = sel;
            state_nx = SEND;
          end else begin
            pop[sel] = 1'b1;
            drop     = 1'b1;
          end
        end
      end
      SEND: begin
        if ((!st_valid || st_ready) && !empty[grant]) begin
          load       = 1'b1;
          pop[grant] = 1'b1;
          if (head[grant][128]) begin
            state_nx = IDLE;
            ptr_nx   = (grant == NW'(ncount - 1)) ? '0 : grant + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state      <= IDLE;
      grant      <= '0;
      ptr        <= '0;
      st_valid   <= 1'b0;
      st_sop     <= 1'b0;
      st_eop     <= 1'b0;
      st_data    <= '0;
      st_channel <= '0;
      drop_count <= '0;
      pkt_count  <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      ptr   <= ptr_nx;
      if (load) begin
        {st_channel, st_sop, st_eop, st_data} <= head[grant];
        st_valid <= 1'b1;
      end else if (st_ready) begin
        st_valid <= 1'b0;
      end
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      if (load && head[grant][128])       pkt_count  <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_out_fifo_network.sv
// Directed bench for out_fifo_network: a cycle table for a single packet,
// then hand-written sequences for arbitration, stalls, backpressure, drops, reset.
module tb_out_fifo_network;

  localparam int N = 8;

  logic               clock = 1'b0;
  logic               sclr;
  logic [N*138-1:0]   pnode_data;
  logic [N-1:0]       pnode_valid;
  logic [N-1:0]       pnode_ready;
  logic [127:0]       st_data;
  logic [7:0]         st_channel;
  logic               st_sop, st_eop, st_valid;
  logic               st_ready;
  logic [15:0]        drop_count;
  logic [31:0]        pkt_count;

  out_fifo_network #(.ncount(N), .FIFO_DEPTH(16)) dut (
    .clock(clock), .sclr(sclr),
    .pnode_data(pnode_data), .pnode_valid(pnode_valid), .pnode_ready(pnode_ready),
    .st_data(st_data), .st_channel(st_channel), .st_sop(st_sop), .st_eop(st_eop),
    .st_valid(st_valid), .st_ready(st_ready),
    .drop_count(drop_count), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  logic [137:0] cap_q[$];
  int           cap_cyc[$];
  logic [137:0] exp_q[$];
  int           cyc = 0;
  logic         prev_v = 1'b0, prev_r = 1'b0, prev_sclr = 1'b0;
  logic [137:0] prev_w = '0;

  wire [137:0] out_word = {st_channel, st_sop, st_eop, st_data};

  // Transfers and stall behaviour observed mid-cycle, where inputs are settled.
  always @(negedge clock) begin
    cyc++;
    if (prev_v && !prev_r && !prev_sclr) begin
      n_chk++;
      if (!(st_valid === 1'b1 && out_word === prev_w)) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%0b word=%h, required v=1 word=%h", st_valid, out_word, prev_w);
      end
    end
    if (st_valid === 1'b1 && st_ready === 1'b1 && sclr === 1'b0) begin
      cap_q.push_back(out_word);
      cap_cyc.push_back(cyc);
    end
    prev_v    = st_valid;
    prev_r    = st_ready;
    prev_sclr = sclr;
    prev_w    = out_word;
  end

  function automatic logic [137:0] mkw(input logic [7:0] ch, input logic s, input logic e,
                                       input logic [127:0] d);
    return {ch, s, e, d};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [137:0] act, input logic [137:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic set_node(input int n, input logic v, input logic [137:0] w);
    pnode_valid[n]          = v;
    pnode_data[n*138 +: 138] = w;
  endtask

  task automatic wait_out(input string nm, input int n, input int budget);
    int c = 0;
    while (cap_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    n_chk++;
    if (cap_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d words, required %0d", nm, cap_q.size(), n);
    end
  endtask

  task automatic check_cap(input string nm);
    check({nm, "_count"}, 138'(cap_q.size()), 138'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_w%0d", nm, i), cap_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    sclr        = 1'b1;
    pnode_valid = '0;
    tick();
    sclr = 1'b0;
  endtask

  typedef struct {
    logic         vld;
    logic [137:0] word;
    logic         rdy;
    logic         exp_v;
    logic [137:0] exp_w;
    logic [31:0]  exp_pkt;
  } vec_t;

  vec_t tbl[7];
  int   idx;
  logic rs;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    // Single 4-word packet from node 2, one row per clock.
    tbl[0] = '{1'b1, mkw(8'h05, 1'b1, 1'b0, 128'hA0), 1'b1, 1'b0, '0, 32'd0};
    tbl[1] = '{1'b1, mkw(8'h05, 1'b0, 1'b0, 128'hA1), 1'b1, 1'b0, '0, 32'd0};
    tbl[2] = '{1'b1, mkw(8'h05, 1'b0, 1'b0, 128'hA2), 1'b1, 1'b1, mkw(8'h05, 1'b1, 1'b0, 128'hA0), 32'd0};
    tbl[3] = '{1'b1, mkw(8'h05, 1'b0, 1'b1, 128'hA3), 1'b1, 1'b1, mkw(8'h05, 1'b0, 1'b0, 128'hA1), 32'd0};
    tbl[4] = '{1'b0, '0, 1'b1, 1'b1, mkw(8'h05, 1'b0, 1'b0, 128'hA2), 32'd0};
    tbl[5] = '{1'b0, '0, 1'b1, 1'b1, mkw(8'h05, 1'b0, 1'b1, 128'hA3), 32'd1};
    tbl[6] = '{1'b0, '0, 1'b1, 1'b0, '0, 32'd1};

    pnode_data  = '0;
    pnode_valid = '0;
    st_ready    = 1'b1;
    sclr        = 1'b1;
    tick();
    do_reset();
    check("rst_valid", 138'(st_valid), 138'(0));
    check("rst_word", out_word, '0);
    check("rst_drop", 138'(drop_count), 138'(0));
    check("rst_pkt", 138'(pkt_count), 138'(0));
    check("rst_ready", 138'(pnode_ready), 138'(8'hFF));

    for (int r = 0; r < 7; r++) begin
      set_node(2, tbl[r].vld, tbl[r].word);
      st_ready = tbl[r].rdy;
      tick();
      check($sformatf("t1_valid_r%0d", r), 138'(st_valid), 138'(tbl[r].exp_v));
      if (tbl[r].exp_v) check($sformatf("t1_word_r%0d", r), out_word, tbl[r].exp_w);
      check($sformatf("t1_pkt_r%0d", r), 138'(pkt_count), 138'(tbl[r].exp_pkt));
    end

    // Nodes 0,1,3 loaded together; ptr starts at 0 after reset.
    do_reset();
    cap_q.delete(); cap_cyc.delete(); exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      foreach (exp_q[i]) ;
      set_node(0, 1'b1, mkw(8'h20, k == 0, k == 2, 128'h200 + k));
      set_node(1, 1'b1, mkw(8'h21, k == 0, k == 2, 128'h210 + k));
      set_node(3, 1'b1, mkw(8'h23, k == 0, k == 2, 128'h230 + k));
      tick();
    end
    pnode_valid = '0;
    for (int k = 0; k < 3; k++) exp_q.push_back(mkw(8'h20, k == 0, k == 2, 128'h200 + k));
    for (int k = 0; k < 3; k++) exp_q.push_back(mkw(8'h21, k == 0, k == 2, 128'h210 + k));
    for (int k = 0; k < 3; k++) exp_q.push_back(mkw(8'h23, k == 0, k == 2, 128'h230 + k));
    wait_out("t2", 9, 60);
    check_cap("t2");
    if (cap_cyc.size() >= 9) begin
      check("t2_inpkt_gap", 138'(cap_cyc[1] - cap_cyc[0]), 138'(1));
      check("t2_gap_n0_n1", 138'(cap_cyc[3] - cap_cyc[2]), 138'(2));
      check("t2_gap_n1_n3", 138'(cap_cyc[6] - cap_cyc[5]), 138'(2));
    end

    // 6-word packet on node 6, drained with st_ready toggling 1010.
    cap_q.delete(); exp_q.delete();
    st_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_node(6, 1'b1, mkw(8'h66, k == 0, k == 5, 128'h300 + k));
      exp_q.push_back(mkw(8'h66, k == 0, k == 5, 128'h300 + k));
      tick();
    end
    set_node(6, 1'b0, '0);
    check("t3_held_valid", 138'(st_valid), 138'(1));
    check("t3_held_word", out_word, mkw(8'h66, 1'b1, 1'b0, 128'h300));
    for (int i = 0; i < 40 && cap_q.size() < 6; i++) begin
      st_ready = (i % 2 == 0);
      tick();
    end
    st_ready = 1'b1;
    repeat (4) tick();
    check_cap("t3");

    // Node 5 backpressure while node 0 owns a stalled output.
    cap_q.delete(); exp_q.delete();
    st_ready = 1'b0;
    set_node(0, 1'b1, mkw(8'h10, 1'b1, 1'b0, 128'h400));
    tick();
    set_node(0, 1'b0, '0);
    repeat (3) tick();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      set_node(5, 1'b1, mkw(8'h55, idx == 0, idx == 19, 128'h500 + idx));
      rs = pnode_ready[5];
      tick();
      if (rs) idx++;
    end
    check("t4_accepted", 138'(idx), 138'(16));
    check("t4_ready_low", 138'(pnode_ready[5]), 138'(0));
    set_node(0, 1'b1, mkw(8'h10, 1'b0, 1'b1, 128'h401));
    tick();
    set_node(0, 1'b0, '0);
    st_ready = 1'b1;
    for (int c = 0; c < 100 && idx < 20; c++) begin
      set_node(5, 1'b1, mkw(8'h55, idx == 0, idx == 19, 128'h500 + idx));
      rs = pnode_ready[5];
      tick();
      if (rs) idx++;
    end
    set_node(5, 1'b0, '0);
    exp_q.push_back(mkw(8'h10, 1'b1, 1'b0, 128'h400));
    exp_q.push_back(mkw(8'h10, 1'b0, 1'b1, 128'h401));
    for (int k = 0; k < 20; k++) exp_q.push_back(mkw(8'h55, k == 0, k == 19, 128'h500 + k));
    wait_out("t4", 22, 200);
    repeat (3) tick();
    check_cap("t4");

    // Node 4: two heads without sop dropped, then a clean packet.
    cap_q.delete(); exp_q.delete();
    set_node(4, 1'b1, mkw(8'h44, 1'b0, 1'b0, 128'hBAD1)); tick();
    set_node(4, 1'b1, mkw(8'h44, 1'b0, 1'b1, 128'hBAD2)); tick();
    for (int k = 0; k < 3; k++) begin
      set_node(4, 1'b1, mkw(8'h44, k == 0, k == 2, 128'hC0 + k));
      exp_q.push_back(mkw(8'h44, k == 0, k == 2, 128'hC0 + k));
      tick();
    end
    set_node(4, 1'b0, '0);
    wait_out("t5", 3, 40);
    repeat (3) tick();
    check_cap("t5");
    check("t5_drop", 138'(drop_count), 138'(2));
    check("t5_pkt", 138'(pkt_count), 138'(7));

    // Reset in the middle of an 8-word packet from node 1.
    for (int k = 0; k < 8; k++) begin
      set_node(1, 1'b1, mkw(8'h11, k == 0, k == 7, 128'h600 + k));
      tick();
    end
    set_node(1, 1'b0, '0);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    check("t6_valid", 138'(st_valid), 138'(0));
    check("t6_drop", 138'(drop_count), 138'(0));
    check("t6_pkt", 138'(pkt_count), 138'(0));
    check("t6_ready", 138'(pnode_ready), 138'(8'hFF));
    cap_q.delete(); exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      set_node(0, 1'b1, mkw(8'h33, k == 0, k == 1, 128'h700 + k));
      exp_q.push_back(mkw(8'h33, k == 0, k == 1, 128'h700 + k));
      tick();
    end
    set_node(0, 1'b0, '0);
    wait_out("t6", 2, 40);
    repeat (10) tick();
    check_cap("t6");
    check("t6_pkt_after", 138'(pkt_count), 138'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
